// File: rtl/popcount_pkg.sv
// Shared definitions for the XNOR popcount accumulator: FSM state type and
// the accumulator width helper.
package popcount_pkg;

    // FSM state encoding
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ACCUM = 2'd1;
    localparam state_t ST_HOLD  = 2'd2;

    // Width needed to hold any total from 0 to inputs*max_beats
    function automatic int acc_bits(input int inputs, input int max_beats);
        return $clog2(inputs * max_beats + 1);
    endfunction

endpackage

// File: rtl/popcount_tree.sv
// Combinational population count built as a balanced binary adder tree.
// The vector is split in halves recursively until single bits remain.
module popcount_tree #(
    parameter int INPUTS = 16,
    localparam int OUT_BITS = $clog2(INPUTS + 1)
) (
    input  logic [INPUTS-1:0]   bits,
    output logic [OUT_BITS-1:0] count
);

    generate
        if (INPUTS == 1) begin : g_leaf
            assign count = bits;
        end else begin : g_split
            localparam int LO = INPUTS / 2;
            localparam int HI = INPUTS - LO;
            localparam int LW = $clog2(LO + 1);
            localparam int HW = $clog2(HI + 1);

            logic [LW-1:0] lo_count;
            logic [HW-1:0] hi_count;

            popcount_tree #(.INPUTS(LO)) u_lo (
                .bits  (bits[LO-1:0]),
                .count (lo_count)
            );

            popcount_tree #(.INPUTS(HI)) u_hi (
                .bits  (bits[INPUTS-1:LO]),
                .count (hi_count)
            );

            // Sum the two halves at the full output width
            assign count = OUT_BITS'(lo_count) + OUT_BITS'(hi_count);
        end
    endgenerate

endmodule

// File: rtl/xnor_popcount_acc.sv
// XNOR popcount accumulator: counts matching bits between activations and
// weights per beat and sums them over a vector of up to MAX_BEATS beats.
// Optional threshold compare is enabled by macro XNOR_POPCOUNT_THRESHOLD_EN.
//
// Handshake: a beat transfers when in_valid && in_ready; a result transfers
// when out_valid && out_ready. Producers hold data stable while valid is
// high and not yet accepted; the result registers hold while out_valid is
// high and out_ready is low.
module xnor_popcount_acc
    import popcount_pkg::*;
#(
    parameter int INPUTS    = 16,
    parameter int MAX_BEATS = 8,
    localparam int ACC_BITS = acc_bits(INPUTS, MAX_BEATS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INPUTS-1:0]   in_data,
    input  logic [INPUTS-1:0]   in_weight,
    input  logic                in_last,
    input  logic                clear,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_BITS-1:0] out_count,
    output logic                out_trunc,
    output logic [1:0]          state_dbg
`ifdef XNOR_POPCOUNT_THRESHOLD_EN
    ,
    input  logic [ACC_BITS-1:0] threshold,
    output logic                out_sign
`endif
);

    localparam int PC_BITS   = $clog2(INPUTS + 1);
    localparam int BEAT_BITS = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    state_t                state;
    logic [ACC_BITS-1:0]   acc;
    logic [BEAT_BITS-1:0]  beats;
    logic [PC_BITS-1:0]    pc;
    logic [ACC_BITS-1:0]   sum;
    logic                  accept;
    logic                  at_max;
    logic                  final_beat;

    popcount_tree #(.INPUTS(INPUTS)) u_tree (
        .bits  (~(in_data ^ in_weight)),
        .count (pc)
    );

    assign in_ready   = (state != ST_HOLD) || out_ready;
    assign accept     = in_valid && in_ready;
    assign sum        = acc + ACC_BITS'(pc);
    assign at_max     = (beats == BEAT_BITS'(MAX_BEATS - 1));
    assign final_beat = in_last || at_max;
    assign state_dbg  = state;

    // FSM, accumulator and result registers; clear beats everything else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc       <= '0;
            beats     <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
            out_trunc <= 1'b0;
        end else if (clear) begin
            state     <= ST_IDLE;
            acc       <= '0;
            beats     <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            if (final_beat) begin
                state     <= ST_HOLD;
                acc       <= '0;
                beats     <= '0;
                out_valid <= 1'b1;
                out_count <= sum;
                out_trunc <= !in_last;
            end else begin
                // A non-last beat taken in HOLD also retires the old result
                state     <= ST_ACCUM;
                acc       <= sum;
                beats     <= beats + BEAT_BITS'(1);
                out_valid <= 1'b0;
            end
        end else if (state == ST_HOLD && out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
        end
    end

`ifdef XNOR_POPCOUNT_THRESHOLD_EN
    // Sign bit registered with the count, comparing against threshold
    // as seen on the final beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sign <= 1'b0;
        end else if (!clear && accept && final_beat) begin
            out_sign <= (sum >= threshold);
        end
    end
`endif

endmodule

// File: doc/xnor_popcount_acc.md
XNOR_POPCOUNT_ACC -- requirements
Module: xnor_popcount_acc

Interface
REQ-001 SHALL have parameter INPUTS, default 16: bits per beat, allowed 4..64.
REQ-002 SHALL have parameter MAX_BEATS, default 8: beats per accumulation, allowed 1..256.
REQ-003 SHALL have derived localparam ACC_BITS = clog2(INPUTS*MAX_BEATS+1).
REQ-004 SHALL have one clock and an asynchronous active-low reset; ports clk (input, 1) and rst_n (input, 1), listed first.
REQ-005 SHALL have in_valid (input, 1): beat offered.
REQ-006 SHALL have in_ready (output, 1): beat accepted when in_valid && in_ready.
REQ-007 SHALL have in_data (input, INPUTS): activations.
REQ-008 SHALL have in_weight (input, INPUTS): weights.
REQ-009 SHALL have in_last (input, 1): final beat of the vector.
REQ-010 SHALL have clear (input, 1): synchronous abort.
REQ-011 SHALL have out_valid (output, 1): result available.
REQ-012 SHALL have out_ready (input, 1): result consumed when out_valid && out_ready.
REQ-013 SHALL have out_count (output, ACC_BITS): accumulated match count.
REQ-014 SHALL have out_trunc (output, 1): vector cut at MAX_BEATS.
REQ-015 SHALL have threshold (input, ACC_BITS) and out_sign (output, 1), present only under the configuration macro.

Function
REQ-016 SHALL compute per beat pc = number of 1 bits in ~(in_data ^ in_weight), range 0..INPUTS.
REQ-017 SHALL use a three-state FSM with states IDLE, ACCUM and HOLD.
REQ-018 SHALL, on an accepted non-last beat, set acc <= acc + pc and beats <= beats + 1, and go to ACCUM.
REQ-019 SHALL, on an accepted last beat, load out_count <= acc + pc, set out_valid, clear acc and beats, and go to HOLD; out_valid rises the cycle after acceptance.
REQ-020 SHALL treat the MAX_BEATS-th accepted beat without in_last as last and set out_trunc=1; out_trunc SHALL otherwise load 0.
REQ-021 SHALL drive in_ready = (state != HOLD) || out_ready.
REQ-022 SHALL hold out_count, out_trunc and out_sign stable while out_valid && !out_ready.
REQ-023 SHALL, in HOLD with out_ready=1 and a beat accepted in the same cycle, retire the old result and process the beat per REQ-018/019 with no bubble.
REQ-024 SHALL, in HOLD with out_ready=1 and no beat, deassert out_valid and go to IDLE.
REQ-025 SHALL never overflow acc; ACC_BITS covers INPUTS*MAX_BEATS.
REQ-026 SHALL, when clear=1, zero acc and beats, deassert out_valid, go to IDLE and ignore any beat that cycle; clear SHALL take priority over all other events.

Reset
REQ-027 SHALL, while rst_n=0, force state=IDLE, acc=0, beats=0, out_valid=0, out_count=0, out_trunc=0 and out_sign=0; in_ready=1 after reset.
REQ-028 SHALL, when reset is asserted mid-vector, discard the partial sum; no result is emitted.

Configuration
REQ-029 SHALL gate the threshold feature with macro XNOR_POPCOUNT_THRESHOLD_EN.
REQ-030 SHALL, with the macro defined, register out_sign = (acc + pc >= threshold) alongside out_count, sampling threshold on the final beat.
REQ-031 SHALL, without the macro, omit the threshold and out_sign ports and the comparator logic.

Structure
REQ-032 SHALL place the FSM state typedef and the ACC_BITS width function in package popcount_pkg.
REQ-033 SHALL implement REQ-016 in a combinational sub-module popcount_tree (parameter INPUTS, balanced adder tree, output clog2(INPUTS+1) bits).

Verification
REQ-034 SHALL cover: INPUTS=16, one last beat with data=weight=16'hFFFF -> out_count=16, out_trunc=0, out_valid one cycle later.
REQ-035 SHALL cover: 3 beats with pc 16, 0, 5 (last on the third) -> out_count=21.
REQ-036 SHALL cover: MAX_BEATS=8, 8 beats of pc=16 with no in_last -> out_count=128, out_trunc=1, the next beat starts a new vector.
REQ-037 SHALL cover: out_ready held 0 for 5 cycles -> in_ready=0, outputs stable; then out_ready=1 together with a last beat of pc=3 -> the old result retires and out_count=3 follows next cycle.
REQ-038 SHALL cover: clear or rst_n=0 after 2 beats -> out_valid stays 0, and the next vector sums from 0.
REQ-039 SHALL cover, with the macro defined: threshold=10, total 10 -> out_sign=1; total 9 -> out_sign=0.
